// File: rtl/rgb_pwm_fader.sv
// RGB LED driver: captures a 3-bit on/off colour code and drives three PWM pins,
// ramping each channel's duty level linearly toward its new target on every colour change.
module rgb_pwm_fader #(
    parameter int DUTY_W   = 8,
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] rgb_in,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       busy
);

    localparam logic [DUTY_W-1:0] MAX_LVL   = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] PWM_LAST  = MAX_LVL - DUTY_W'(1);
    localparam int                SC_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SC_W-1:0]   STEP_LAST = SC_W'(STEP_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [SC_W-1:0]              step_q, step_d;
    logic [2:0][DUTY_W-1:0]       lvl_q, lvl_d;
    logic [2:0][DUTY_W-1:0]       tgt;
    logic [DUTY_W-1:0]            pwm_cnt;
    logic [2:0]                   rgb_q;
    logic                         at_tgt;

    // Index 2/1/0 = red/green/blue, matching the bit order of rgb_in.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tgt[i] = rgb_q[i] ? MAX_LVL : '0;
        end
    end

    assign at_tgt = (lvl_q == tgt);
    assign busy   = (state_q == FADE);

    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lvl_d   = lvl_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (!at_tgt) begin
                        state_d = FADE;
                        step_d  = '0;
                    end
                end
                FADE: begin
                    if (at_tgt) begin
                        state_d = IDLE;
                    end else if (step_q == STEP_LAST) begin
                        step_d = '0;
                        // Targets are only 0 or MAX_LVL, so a +/-1 move toward them can never wrap.
                        for (int i = 0; i < 3; i++) begin
                            if (lvl_q[i] < tgt[i]) begin
                                lvl_d[i] = lvl_q[i] + DUTY_W'(1);
                            end else if (lvl_q[i] > tgt[i]) begin
                                lvl_d[i] = lvl_q[i] - DUTY_W'(1);
                            end
                        end
                    end else begin
                        step_d = step_q + SC_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            lvl_q   <= '0;
            rgb_q   <= '0;
            pwm_cnt <= '0;
            led_r   <= 1'b0;
            led_g   <= 1'b0;
            led_b   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lvl_q   <= lvl_d;
            rgb_q   <= rgb_in;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + DUTY_W'(1);
            // Period is MAX_LVL cycles, so lvl = MAX_LVL is always high and lvl = 0 always low.
            led_r   <= en & (pwm_cnt < lvl_q[2]);
            led_g   <= en & (pwm_cnt < lvl_q[1]);
            led_b   <= en & (pwm_cnt < lvl_q[0]);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader (DUTY_W=4, STEP_DIV=2): fade lengths, PWM window counts and
// snapshots are queued by the stimulus and checked by a negedge monitor when the DUT presents them.
module tb_rgb_pwm_fader;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] rgb_in;
    logic       led_r, led_g, led_b, busy;

    rgb_pwm_fader #(.DUTY_W(4), .STEP_DIV(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .rgb_in (rgb_in),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { string name; int len; } fade_t;
    typedef struct { string name; int r; int g; int b; int bz; } win_t;
    typedef struct { string name; int v; } snap_t;

    fade_t fade_q[$];
    win_t  win_q[$];
    snap_t snap_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic smp     = 1'b0;
    logic win_req = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: fade completes on a busy falling edge; windows count 15 samples = one PWM period.
    int busy_run = 0;
    int win_left = 0;
    int wc_r, wc_g, wc_b, wc_bz;
    initial begin
        fade_t fe;
        win_t  we;
        snap_t se;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                if (fade_q.size() == 0) begin
                    check("unexpected_fade", busy_run, 0);
                end else begin
                    fe = fade_q.pop_front();
                    check(fe.name, busy_run, fe.len);
                end
                busy_run = 0;
            end
            if (smp) begin
                if (snap_q.size() == 0) begin
                    check("snap_q_empty", 0, 1);
                end else begin
                    se = snap_q.pop_front();
                    check(se.name, int'({led_r, led_g, led_b, busy}), se.v);
                end
            end
            if (win_req && win_left == 0) begin
                win_left = 15;
                wc_r = 0; wc_g = 0; wc_b = 0; wc_bz = 0;
            end
            if (win_left != 0) begin
                wc_r  += int'(led_r);
                wc_g  += int'(led_g);
                wc_b  += int'(led_b);
                wc_bz += int'(busy);
                win_left--;
                if (win_left == 0) begin
                    if (win_q.size() == 0) begin
                        check("win_q_empty", 0, 1);
                    end else begin
                        we = win_q.pop_front();
                        check({we.name, "_r"},    wc_r,  we.r);
                        check({we.name, "_g"},    wc_g,  we.g);
                        check({we.name, "_b"},    wc_b,  we.b);
                        check({we.name, "_busy"}, wc_bz, we.bz);
                    end
                end
            end
        end
    end

    task automatic expect_fade(input string name, input int len);
        fade_t f;
        f.name = name; f.len = len;
        fade_q.push_back(f);
    endtask

    task automatic window(input string name, input int r, input int g, input int b, input int bz);
        win_t w;
        w.name = name; w.r = r; w.g = g; w.b = b; w.bz = bz;
        win_q.push_back(w);
        #1 win_req = 1'b1;
        @(negedge clk);
        #1 win_req = 1'b0;
        repeat (14) @(negedge clk);
        #1;
    endtask

    task automatic snap(input string name, input int v);
        snap_t s;
        s.name = name; s.v = v;
        snap_q.push_back(s);
        #1 smp = 1'b1;
        @(negedge clk);
        #1 smp = 1'b0;
    endtask

    task automatic set_rgb(input logic [2:0] v);
        @(posedge clk);
        #1 rgb_in = v;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!busy) check("busy_rise_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_fall_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        rgb_in = 3'b000;
        repeat (3) @(posedge clk);
        #1 snap("reset_state", 0);
        @(posedge clk);
        #1 reset = 1'b0;
        window("idle_dark", 0, 0, 0, 0);

        // Ramp up red: entry takes 2 edges, then 15 steps x 2 cycles plus the settle cycle.
        expect_fade("ramp_up_len", 31);
        set_rgb(3'b100);
        wait_busy();
        wait_idle();
        window("ramp_up_end", 15, 0, 0, 0);

        expect_fade("ramp_down_len", 31);
        set_rgb(3'b000);
        wait_busy();
        wait_idle();
        window("ramp_down_end", 0, 0, 0, 0);

        // Reversal at level 7: one more timer tick, then 7 down-steps; busy spans 29 samples.
        expect_fade("reversal_len", 29);
        set_rgb(3'b100);
        wait_busy();
        repeat (14) @(posedge clk);
        #1 rgb_in = 3'b000;
        wait_idle();
        window("reversal_end", 0, 0, 0, 0);

        // Enable gate: 20 frozen edges extend busy from 31 to 51 samples.
        expect_fade("en_gate_len", 51);
        set_rgb(3'b100);
        wait_busy();
        repeat (9) @(posedge clk);
        #1 en = 1'b0;
        repeat (2) @(posedge clk);
        window("gate_dark", 0, 0, 0, 15);
        repeat (4) @(posedge clk);
        #1 en = 1'b1;
        wait_idle();
        window("gate_end", 15, 0, 0, 0);

        // Mixed fades: green joins, then red falls while blue rises in lockstep.
        expect_fade("to_110_len", 31);
        set_rgb(3'b110);
        wait_busy();
        wait_idle();
        window("settle_110", 15, 15, 0, 0);
        expect_fade("mixed_len", 31);
        set_rgb(3'b011);
        wait_busy();
        wait_idle();
        window("settle_011", 0, 15, 15, 0);

        // Input toggling while disabled only updates the capture register.
        @(posedge clk);
        #1 en = 1'b0;
        rgb_in = 3'b001;
        repeat (3) @(posedge clk);
        #1 rgb_in = 3'b110;
        repeat (3) @(posedge clk);
        #1 rgb_in = 3'b100;
        repeat (5) @(posedge clk);
        snap("en_off_frozen", 0);
        expect_fade("en_resume_len", 31);
        en = 1'b1;
        wait_busy();
        wait_idle();
        window("en_resume_end", 15, 0, 0, 0);

        expect_fade("clear_len", 31);
        set_rgb(3'b000);
        wait_busy();
        wait_idle();

        // Reset between edges at red level 9; the interrupted fade produces no completion event.
        set_rgb(3'b100);
        wait_busy();
        repeat (18) @(posedge clk);
        #2 reset = 1'b1;
        snap("async_reset", 0);
        expect_fade("post_reset_len", 31);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_busy();
        wait_idle();
        window("post_reset_end", 15, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("fade_q_left", fade_q.size(), 0);
        check("win_q_left", win_q.size(), 0);
        check("snap_q_left", snap_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
